ysyx_22041211_mem_arbiter: RTL

Two-master, one-slave memory arbiter that places the instruction fetch unit (IFU) and the load/store unit (LSU) on a single shared memory port. It sits between the fetch stage, the EXE/LSU path (`mem_wen`, `mem_wdata`, `load_type` consumers) and the single memory model. It serialises requests, with one transaction outstanding at a time. A response watchdog converts a hung slave into an error response, so the core cannot deadlock.

---
 rtl/ysyx_22041211_mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041211_mem_arbiter.sv
// ============================================================================
// ysyx_22041211_mem_arbiter : IFU/LSU to single memory port arbiter with watchdog
// Option macro YSYX_22041211_ARB_RR_EN selects round-robin (else LSU priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22041211_mem_arbiter #(
  parameter int DATA_LEN       = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [DATA_LEN-1:0] ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_LEN-1:0] ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [DATA_LEN-1:0] lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [3:0]          lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_wen,
  output logic [3:0]          mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [7:0]          TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [DATA_LEN-1:0] ERR_DATA    = DATA_LEN'(32'hDEAD_BEEF);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        grant_lsu;
  logic        rsp_fire;
  logic [DATA_LEN-1:0] rsp_data;

`ifdef YSYX_22041211_ARB_RR_EN
  // On a tie the master that did not win last time is served.
  always_comb begin
    grant_lsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) begin
      grant_lsu = ~last_grant_q;
    end
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rdata     = '0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wen       = 1'b0;
    mem_wmask     = 4'b0000;
    bus_err       = 1'b0;
    rsp_fire      = 1'b0;
    rsp_data      = '0;

    case (state_q)
      ST_IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          owner_d = grant_lsu;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (owner_q) begin
          mem_addr      = lsu_addr;
          mem_wdata     = lsu_wdata;
          mem_wen       = lsu_wen;
          mem_wmask     = lsu_wmask;
          lsu_req_ready = mem_req_ready;
        end else begin
          mem_addr      = ifu_addr;
          ifu_req_ready = mem_req_ready;
        end
        if (mem_req_ready) begin
          state_d      = ST_WAIT;
          wait_cnt_d   = 8'd0;
          last_grant_d = owner_q;
        end
      end

      ST_WAIT: begin
        // A real response in the watchdog cycle takes precedence over the error.
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_data = mem_rdata;
          state_d  = ST_IDLE;
        end else if (wait_cnt_q == TIMEOUT_LIM) begin
          rsp_fire = 1'b1;
          rsp_data = ERR_DATA;
          bus_err  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rsp_fire) begin
      if (owner_q) begin
        lsu_rsp_valid = 1'b1;
        lsu_rdata     = rsp_data;
      end else begin
        ifu_rsp_valid = 1'b1;
        ifu_rdata     = rsp_data;
      end
    end
  end

endmodule

`default_nettype wire
